// File: rtl/pc_gen_unit.sv
// Fetch program-counter generator: sequential advance, branch/exception/eret
// redirects, stall-time redirect buffering, fetch-address check and redirect counter.
module pc_gen_unit #(
   parameter int unsigned     WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_3000,
   parameter logic [WIDTH-1:0] EXC_PC   = 32'h0000_4180,
   parameter logic [WIDTH-1:0] IMEM_LO  = 32'h0000_3000,
   parameter logic [WIDTH-1:0] IMEM_HI  = 32'h0000_6FFF,
   parameter int unsigned     STEP     = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             br_valid,
   input  logic [WIDTH-1:0] br_target,
   input  logic             exc_req,
   input  logic             eret_req,
   input  logic [WIDTH-1:0] epc,
   output logic [WIDTH-1:0] pc,
   output logic             pend,
   output logic             adel,
   output logic [15:0]      redir_cnt
);

   localparam int unsigned CNT_W = 16;

   // Declaration values make pre-reset simulation state match the reset state.
   logic [WIDTH-1:0] pc_q   = RESET_PC;
   logic [WIDTH-1:0] pc_d;
   logic             pend_q = 1'b0;
   logic             pend_d;
   logic [WIDTH-1:0] ptgt_q = '0;
   logic [WIDTH-1:0] ptgt_d;
   logic [CNT_W-1:0] cnt_q  = '0;
   logic [CNT_W-1:0] cnt_d;

   // Priority-ordered next-state selection; exactly one action per edge.
   always_comb begin
      pc_d   = pc_q;
      pend_d = pend_q;
      ptgt_d = ptgt_q;
      cnt_d  = cnt_q;
      if (exc_req) begin
         pc_d   = EXC_PC;
         pend_d = 1'b0;
         cnt_d  = cnt_q + CNT_W'(1);
      end else if (eret_req) begin
         pc_d   = epc;
         pend_d = 1'b0;
         cnt_d  = cnt_q + CNT_W'(1);
      end else if (br_valid && en) begin
         pc_d   = br_target;
         pend_d = 1'b0;
         cnt_d  = cnt_q + CNT_W'(1);
      end else if (br_valid) begin
         // Stalled redirect: buffer it, latest request wins.
         pend_d = 1'b1;
         ptgt_d = br_target;
      end else if (pend_q && en) begin
         pc_d   = ptgt_q;
         pend_d = 1'b0;
         cnt_d  = cnt_q + CNT_W'(1);
      end else if (en) begin
         pc_d   = pc_q + WIDTH'(STEP);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q   <= RESET_PC;
         pend_q <= 1'b0;
         ptgt_q <= '0;
         cnt_q  <= '0;
      end else begin
         pc_q   <= pc_d;
         pend_q <= pend_d;
         ptgt_q <= ptgt_d;
         cnt_q  <= cnt_d;
      end
   end

   assign pc        = pc_q;
   assign pend      = pend_q;
   assign redir_cnt = cnt_q;
   assign adel      = (pc_q[1:0] != 2'b00) || (pc_q < IMEM_LO) || (pc_q > IMEM_HI);

endmodule
